// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter with a per-tenure hold limit and a one-cycle dead slot
// between tenures; every output comes straight from a flop.
module rr_arbiter_ctrl #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N),
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           reset_L,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           busy_q, busy_d;
  logic           timeout_q, timeout_d;
  logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           arb_valid;
  logic [IDW-1:0] arb_winner;
  logic           owner_req;
  logic           hold_full;

  // Index arithmetic modulo N that stays correct when N is not a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return IDW'(sum);
  endfunction

  // Scanning from the far end back toward ptr leaves the first requester
  // at or after ptr as the final assignment.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    arb_valid  = 1'b0;
    arb_winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr_q, k)]) begin
        arb_valid  = 1'b1;
        arb_winner = wrap_add(ptr_q, k);
      end
    end
  end

  assign owner_req = req[gnt_id_q];
  assign hold_full = (hold_cnt_q == CW'(MAX_HOLD));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;

    unique case (state_q)
      IDLE, GAP: begin
        if (arb_valid) begin
          state_d    = GRANT;
          gnt_d      = '0;
          gnt_d[arb_winner] = 1'b1;
          gnt_id_d   = arb_winner;
          busy_d     = 1'b1;
          hold_cnt_d = CW'(1);
        end else begin
          state_d    = IDLE;
          gnt_d      = '0;
          busy_d     = 1'b0;
        end
      end

      GRANT: begin
        if (!owner_req || hold_full) begin
          // The releasing owner drops to lowest priority for the next round.
          state_d    = GAP;
          gnt_d      = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          ptr_d      = wrap_add(gnt_id_q, 1);
          timeout_d  = owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        gnt_d      = '0;
        busy_d     = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!reset_L) $onehot0(gnt));
  a_busy_gnt    : assert property (@(posedge clk) disable iff (!reset_L) busy == (|gnt));
  a_id_range    : assert property (@(posedge clk) disable iff (!reset_L) int'(gnt_id) < N);
  a_timeout_gap : assert property (@(posedge clk) disable iff (!reset_L) timeout |-> !busy);

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Directed bench for rr_arbiter_ctrl: N=4, MAX_HOLD=8, hand-computed
// expectations for each cycle.
module tb_rr_arbiter_ctrl;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = 2;

  logic           clk;
  logic           reset_L;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_arbiter_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] g,
                            input int id, input logic t);
    check({tag, ".gnt"},     int'(gnt),     int'(g));
    check({tag, ".gnt_id"},  int'(gnt_id),  id);
    check({tag, ".busy"},    int'(busy),    int'(|g));
    check({tag, ".timeout"}, int'(timeout), int'(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] b;
    reset_L = 1'b0;
    req     = '0;

    // Reset state, then idle with no requests.
    #3;
    expect_out("rst", 4'b0000, 0, 1'b0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("idle", 4'b0000, 0, 1'b0);
    end

    // Single requester for three grant cycles; ptr becomes 2.
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("single_gnt", 4'b0010, 1, 1'b0);
    end
    req = 4'b0000;
    tick();
    expect_out("single_gap", 4'b0000, 1, 1'b0);
    tick();
    expect_out("single_idle", 4'b0000, 1, 1'b0);

    // Asynchronous reset in the middle of a tenure.
    req = 4'b0100;
    tick();
    expect_out("pre_rst", 4'b0100, 2, 1'b0);
    #2 reset_L = 1'b0;
    #1 expect_out("async_rst", 4'b0000, 0, 1'b0);
    #2 reset_L = 1'b1;
    req = 4'b0000;
    tick();
    expect_out("post_rst", 4'b0000, 0, 1'b0);

    // Rotation 0,1,2,3,0 with each owner dropping req after two cycles.
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      b = 4'b0001 << (o % N);
      tick();
      expect_out($sformatf("rr%0d_gnt", o), b, o % N, 1'b0);
      tick();
      expect_out($sformatf("rr%0d_hold", o), b, o % N, 1'b0);
      req = 4'b1111 & ~b;
      tick();
      expect_out($sformatf("rr%0d_gap", o), 4'b0000, o % N, 1'b0);
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
    expect_out("rr_idle", 4'b0000, 0, 1'b0);

    // Hold limit: exactly MAX_HOLD grant cycles, timeout pulse, re-grant.
    req = 4'b0001;
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      expect_out($sformatf("hold%0d", i), 4'b0001, 0, 1'b0);
    end
    tick();
    expect_out("hold_timeout", 4'b0000, 0, 1'b1);
    tick();
    expect_out("hold_regrant", 4'b0001, 0, 1'b0);

    // Timeout fairness: owner 0 times out, 1 goes next, then back to 0.
    req = 4'b0011;
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      tick();
      expect_out("fair_o0", 4'b0001, 0, 1'b0);
    end
    tick();
    expect_out("fair_to0", 4'b0000, 0, 1'b1);
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      expect_out("fair_o1", 4'b0010, 1, 1'b0);
    end
    tick();
    expect_out("fair_to1", 4'b0000, 1, 1'b1);
    tick();
    expect_out("fair_back0", 4'b0001, 0, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("fair_gap", 4'b0000, 0, 1'b0);
    tick();
    expect_out("fair_idle", 4'b0000, 0, 1'b0);

    // Wrap: owner 2 releases (ptr=3), req=1001 grants 3, noise on req[0].
    req = 4'b0100;
    tick();
    expect_out("wrap_o2", 4'b0100, 2, 1'b0);
    req = 4'b1001;
    tick();
    expect_out("wrap_gap", 4'b0000, 2, 1'b0);
    tick();
    expect_out("wrap_o3", 4'b1000, 3, 1'b0);
    req = 4'b1000;
    tick();
    expect_out("noise_a", 4'b1000, 3, 1'b0);
    req = 4'b1001;
    tick();
    expect_out("noise_b", 4'b1000, 3, 1'b0);
    req = 4'b1000;
    tick();
    expect_out("noise_c", 4'b1000, 3, 1'b0);
    req = 4'b0001;
    tick();
    expect_out("wrap_gap2", 4'b0000, 3, 1'b0);
    tick();
    expect_out("wrap_o0", 4'b0001, 0, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("wrap_end", 4'b0000, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
